softmax_in_packer: RTL and testbench
====================================

SOFTMAX_IN_PACKER -- requirements
Module: softmax_in_packer

Interface
REQ-001 Parameter N, default 8: elements per output vector (lanes).
REQ-002 Parameter PAD, default 16'h8000: Q8.8 fill value for unused lanes (most negative).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 en  input  1  clock enable; en=0 freezes all state.
REQ-006 s_valid  input  1  scalar element offered this cycle.
REQ-007 s_data  input  16  signed Q8.8 element.
REQ-008 s_last  input  1  with s_valid: final element of a short vector.
REQ-009 s_ready  output  1  element accepted when s_valid & s_ready.
REQ-010 in_x_flat  output  N*16  packed vector; lane k at bits [16k+15:16k].
REQ-011 max_x  output  16  signed maximum of the real (non-pad) lanes.
REQ-012 out_len  output  clog2(N+1)  count of real lanes in the vector (1..N).
REQ-013 valid_out  output  1  one-enabled-cycle pulse; vector outputs valid; wired directly to softmax valid_in.

Function
REQ-014 s_ready SHALL equal en & ~rst; no other back-pressure.
REQ-015 The first accepted element after reset or after vector completion SHALL go to lane 0, each later element to the next lane.
REQ-016 A fill counter (0..N-1) SHALL increment per accepted element and return to 0 on completion.
REQ-017 Completion SHALL occur on the accepted element with counter N-1, or on any accepted element with s_last=1.
REQ-018 On completion, lanes above the last written lane SHALL be set to PAD.
REQ-019 s_last on the N-th element SHALL be a normal full completion with no padding.
REQ-020 Running max SHALL load s_data on the lane-0 element, then take the signed max of itself and s_data; equal values leave it unchanged.
REQ-021 PAD lanes SHALL never affect max_x.
REQ-022 The completing element SHALL be included in max_x.
REQ-023 FSM states: FILL (counter 0..N-1) and a one-shot EMIT flag; no idle wait state.
REQ-024 On completion: in_x_flat, max_x and out_len SHALL be loaded into output registers, and valid_out SHALL assert on the next enabled cycle.
REQ-025 Latency: valid_out SHALL assert 1 enabled cycle after the completing element is accepted.
REQ-026 Output registers SHALL hold their values until the next completion.
REQ-027 Filling the next vector SHALL proceed in parallel with the output registers, giving full throughput (one vector per N elements).
REQ-028 valid_out SHALL equal the internal pulse register AND en.
REQ-029 The pulse register SHALL clear after one enabled cycle.
REQ-030 If en drops while the pulse is pending, the pulse SHALL be presented on the next enabled cycle.
REQ-031 Consecutive single-element vectors (s_last every beat) SHALL produce valid_out on consecutive cycles.
REQ-032 s_data SHALL be ignored when s_valid=0; s_last SHALL be ignored when s_valid=0.

Reset
REQ-033 rst=1 SHALL clear the fill counter, running max, output registers and pulse register, regardless of en.
REQ-034 Values during reset: in_x_flat=0, max_x=0, out_len=0, valid_out=0, s_ready=0.
REQ-035 Reset mid-fill SHALL discard the partial vector with no valid_out.
REQ-036 The first element after reset SHALL go to lane 0.

Verification
REQ-037 Stream 021C,FFDF,FFC4,FEC6,0352,0050,013B,FEE0 (en=1) -> one cycle after the 8th element: valid_out=1, in_x_flat={FEE0,013B,0050,0352,FEC6,FFC4,FFDF,021C} (MSB lane first), max_x=0352, out_len=8.
REQ-038 Eight 0050 elements, then immediately eight 0452 elements -> two pulses 8 cycles apart; max_x=0050 then 0452; first vector stable until the second completes.
REQ-039 0100,FF00, then 0080 with s_last -> lanes 0..2=0100,FF00,0080; lanes 3..7=8000; max_x=0100; out_len=3.
REQ-040 All-negative vector FE00,FD00,8001,FF80,FC00,FE00,FE00,FE00 -> max_x=FF80 (signed compare, not unsigned).
REQ-041 Four elements, rst for 1 cycle, then 8 new elements -> exactly one valid_out, for the new vector only, with lane 0 = first post-reset element.
REQ-042 en=0 for 3 cycles between elements 5 and 6, and again on the cycle after the 8th element -> vector unchanged; s_ready=0 and valid_out=0 while en=0; exactly one valid_out once en=1.

Source files
------------

// File: rtl/softmax_in_packer.sv
// softmax_in_packer
// Collects a stream of signed Q8.8 scalars into an N-lane vector for the
// softmax block. A vector closes after N elements or early on s_last; unused
// upper lanes are filled with PAD. The finished vector, its maximum and its
// real-lane count are held in output registers while the next vector fills,
// and valid_out pulses for one enabled cycle per finished vector.
module softmax_in_packer #(
    parameter int          N   = 8,
    parameter logic [15:0] PAD = 16'h8000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       s_valid,
    input  logic [15:0]                s_data,
    input  logic                       s_last,
    output logic                       s_ready,
    output logic [N*16-1:0]            in_x_flat,
    output logic [15:0]                max_x,
    output logic [$clog2(N+1)-1:0]     out_len,
    output logic                       valid_out
);

    // Counter width covers lanes 0..N-1; length width covers 0..N.
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int LW = $clog2(N + 1);

    localparam logic [CW-1:0] LANE_FIRST = {CW{1'b0}};
    localparam logic [CW-1:0] LANE_LAST  = CW'(N - 1);

    // One-shot emit flag states; the fill counter itself is the FILL state.
    localparam logic [0:0] EMIT_IDLE = 1'b0;
    localparam logic [0:0] EMIT_PEND = 1'b1;

    logic [CW-1:0]  cnt_r;
    logic [15:0]    lane_r [N];
    logic [15:0]    run_max_r;

    logic [N*16-1:0] flat_r;
    logic [15:0]     max_x_r;
    logic [LW-1:0]   len_r;
    logic [0:0]      emit_r;

    logic            accept_s;
    logic            complete_s;
    logic [15:0]     next_max_s;
    logic [N*16-1:0] vec_s;

    // Handshake decode and the running maximum including the current element.
    always_comb begin
        accept_s   = s_valid & en & ~rst;
        complete_s = accept_s & (s_last | (cnt_r == LANE_LAST));
        next_max_s = run_max_r;
        if (cnt_r == LANE_FIRST) begin
            next_max_s = s_data;
        end else if ($signed(s_data) > $signed(run_max_r)) begin
            next_max_s = s_data;
        end else begin
            next_max_s = run_max_r;
        end
    end

    // Completed-vector image: stored lanes below the counter, the incoming
    // element at the counter, PAD above it.
    always_comb begin
        vec_s = {N{PAD}};
        for (int k = 0; k < N; k++) begin
            if (CW'(k) < cnt_r) begin
                vec_s[16*k +: 16] = lane_r[k];
            end else if (CW'(k) == cnt_r) begin
                vec_s[16*k +: 16] = s_data;
            end else begin
                vec_s[16*k +: 16] = PAD;
            end
        end
    end

    // Fill side: lane storage, fill counter and running maximum.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r     <= LANE_FIRST;
            run_max_r <= 16'h0000;
            for (int k = 0; k < N; k++) begin
                lane_r[k] <= 16'h0000;
            end
        end else if (accept_s) begin
            lane_r[cnt_r] <= s_data;
            run_max_r     <= next_max_s;
            cnt_r         <= complete_s ? LANE_FIRST : (cnt_r + CW'(1));
        end
    end

    // Output registers: captured on completion, held until the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            flat_r  <= {(N*16){1'b0}};
            max_x_r <= 16'h0000;
            len_r   <= {LW{1'b0}};
        end else if (complete_s) begin
            flat_r  <= vec_s;
            max_x_r <= next_max_s;
            len_r   <= LW'(cnt_r) + LW'(1);
        end
    end

    // Emit flag: set by a completion, cleared after one enabled cycle,
    // frozen while en is low so a pending pulse is not lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            emit_r <= EMIT_IDLE;
        end else if (en) begin
            emit_r <= complete_s ? EMIT_PEND : EMIT_IDLE;
        end
    end

    assign s_ready   = en & ~rst;
    assign valid_out = (emit_r == EMIT_PEND) & en & ~rst;
    assign in_x_flat = flat_r;
    assign max_x     = max_x_r;
    assign out_len   = len_r;

endmodule

// File: tb/tb_softmax_in_packer.sv
// Testbench for softmax_in_packer: directed vectors plus a randomized stream,
// checked every cycle against a queue-based reference model.
module tb_softmax_in_packer;

    localparam int          N   = 8;
    localparam logic [15:0] PAD = 16'h8000;
    localparam int          LW  = $clog2(N + 1);
    localparam int          W   = N * 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          s_valid;
    logic [15:0]   s_data;
    logic          s_last;
    logic          s_ready;
    logic [W-1:0]  in_x_flat;
    logic [15:0]   max_x;
    logic [LW-1:0] out_len;
    logic          valid_out;

    int n_cmp     = 0;
    int n_fail    = 0;
    int pulse_cnt = 0;
    bit chk_on    = 1'b0;

    // Reference model state
    logic [15:0]   q [$];
    logic [W-1:0]  e_flat = '0;
    logic [15:0]   e_max  = 16'h0000;
    logic [LW-1:0] e_len  = '0;
    bit            e_pend = 1'b0;

    always #5 clk = ~clk;

    softmax_in_packer #(.N(N), .PAD(PAD)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .in_x_flat (in_x_flat),
        .max_x     (max_x),
        .out_len   (out_len),
        .valid_out (valid_out)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Model of one clock edge: a vector is the list of accepted elements,
    // closed by s_last or by reaching N entries.
    task automatic model_edge(input logic v, input logic [15:0] d, input logic l,
                              input logic e, input logic r);
        logic [15:0] m;
        if (r) begin
            q.delete();
            e_flat = '0;
            e_max  = 16'h0000;
            e_len  = '0;
            e_pend = 1'b0;
        end else if (e) begin
            e_pend = 1'b0;
            if (v) begin
                q.push_back(d);
                if (l || q.size() == N) begin
                    for (int k = 0; k < N; k++)
                        e_flat[16*k +: 16] = (k < q.size()) ? q[k] : PAD;
                    m = q[0];
                    foreach (q[i])
                        if ($signed(q[i]) > $signed(m)) m = q[i];
                    e_max  = m;
                    e_len  = LW'(q.size());
                    e_pend = 1'b1;
                    q.delete();
                end
            end
        end
    endtask

    // Drive one cycle, check all outputs before the edge, then advance.
    task automatic cycle(input logic v, input logic [15:0] d, input logic l,
                         input logic e, input logic r);
        s_valid = v; s_data = d; s_last = l; en = e; rst = r;
        #1;
        if (chk_on) begin
            chk("s_ready",   W'(s_ready),   W'(e & ~r));
            chk("valid_out", W'(valid_out), W'(e_pend & e & ~r));
            chk("in_x_flat", in_x_flat,     e_flat);
            chk("max_x",     W'(max_x),     W'(e_max));
            chk("out_len",   W'(out_len),   W'(e_len));
        end
        if (valid_out === 1'b1) pulse_cnt++;
        @(posedge clk);
        model_edge(v, d, l, e, r);
        #1;
    endtask

    task automatic send(input logic [15:0] d, input logic l);
        cycle(1'b1, d, l, 1'b1, 1'b0);
    endtask

    task automatic idle();
        cycle(1'b0, 16'($urandom), 1'($urandom), 1'b1, 1'b0);
    endtask

    logic [15:0] v037 [8] = '{16'h021C, 16'hFFDF, 16'hFFC4, 16'hFEC6,
                              16'h0352, 16'h0050, 16'h013B, 16'hFEE0};
    logic [15:0] v040 [8] = '{16'hFE00, 16'hFD00, 16'h8001, 16'hFF80,
                              16'hFC00, 16'hFE00, 16'hFE00, 16'hFE00};

    initial begin
        int p0;
        logic [W-1:0] vexp;

        s_valid = 1'b0; s_data = 16'h0000; s_last = 1'b0; en = 1'b0; rst = 1'b1;

        // Reset
        cycle(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
        chk_on = 1'b1;
        cycle(1'b1, 16'h1234, 1'b1, 1'b1, 1'b1);
        chk("rst_flat", in_x_flat, {W{1'b0}});
        chk("rst_max",  W'(max_x), W'(16'h0000));
        idle();

        // Full 8-element vector with known result
        foreach (v037[i]) send(v037[i], 1'b0);
        chk("r037_valid", W'(valid_out), W'(1'b1));
        chk("r037_flat", in_x_flat, {16'hFEE0, 16'h013B, 16'h0050, 16'h0352,
                                     16'hFEC6, 16'hFFC4, 16'hFFDF, 16'h021C});
        chk("r037_max", W'(max_x),   W'(16'h0352));
        chk("r037_len", W'(out_len), W'(4'd8));
        idle();

        // Back-to-back vectors at full throughput
        for (int i = 0; i < 8; i++) send(16'h0050, 1'b0);
        chk("r038_max1", W'(max_x), W'(16'h0050));
        for (int i = 0; i < 8; i++) send(16'h0452, 1'b0);
        chk("r038_max2", W'(max_x), W'(16'h0452));
        idle();

        // Short vector with padding
        send(16'h0100, 1'b0);
        send(16'hFF00, 1'b0);
        send(16'h0080, 1'b1);
        chk("r039_flat", in_x_flat, {PAD, PAD, PAD, PAD, PAD,
                                     16'h0080, 16'hFF00, 16'h0100});
        chk("r039_max", W'(max_x),   W'(16'h0100));
        chk("r039_len", W'(out_len), W'(4'd3));
        idle();

        // Signed maximum over all-negative data
        foreach (v040[i]) send(v040[i], 1'b0);
        chk("r040_max", W'(max_x), W'(16'hFF80));
        idle();

        // s_last on the N-th element is a plain full vector
        for (int i = 0; i < 8; i++) send(16'(16'h0010 * i), (i == 7) ? 1'b1 : 1'b0);
        chk("r019_len", W'(out_len), W'(4'd8));
        idle();

        // Consecutive single-element vectors
        p0 = pulse_cnt;
        send(16'h0200, 1'b1);
        send(16'hFE00, 1'b1);
        send(16'h0001, 1'b1);
        idle();
        chk("r031_pulses", W'(pulse_cnt - p0), W'(3));
        chk("r031_len", W'(out_len), W'(4'd1));

        // Reset mid-fill discards the partial vector
        p0 = pulse_cnt;
        for (int i = 0; i < 4; i++) send(16'h0700, 1'b0);
        cycle(1'b1, 16'h0777, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) send(16'(16'h1000 + i), 1'b0);
        idle();
        chk("r041_pulses", W'(pulse_cnt - p0), W'(1));
        chk("r041_lane0",  W'(in_x_flat[15:0]), W'(16'h1000));

        // Clock-enable stalls mid-vector and during the pending pulse
        p0 = pulse_cnt;
        vexp = '0;
        for (int i = 0; i < 5; i++) begin
            send(16'(16'h0300 + i), 1'b0);
            vexp[16*i +: 16] = 16'(16'h0300 + i);
        end
        for (int i = 0; i < 3; i++) cycle(1'b1, 16'($urandom), 1'b1, 1'b0, 1'b0);
        for (int i = 5; i < 8; i++) begin
            send(16'(16'h0300 + i), 1'b0);
            vexp[16*i +: 16] = 16'(16'h0300 + i);
        end
        cycle(1'b1, 16'($urandom), 1'b1, 1'b0, 1'b0);
        idle();
        idle();
        chk("r042_pulses", W'(pulse_cnt - p0), W'(1));
        chk("r042_flat", in_x_flat, vexp);

        // Randomized stream
        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 5) == 0,
                  $urandom_range(0, 7) != 0, $urandom_range(0, 59) == 0);
        end
        idle();
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
